axi_dma_w_arb: RTL and testbench
================================

Name: axi_dma_w_arb

Overview:
- Round-robin, burst-granular arbiter that shares one AXI write-DMA databus port among N_REQ internal requesters (e.g. YOLO layer output writers).
- Sits between the requesters and the write-DMA databus (valid/ready/addr/wdata/wstrb).
- Once granted, a requester owns the DMA for exactly one full burst of BURST_BEATS data beats. Ownership is then released and re-arbitrated.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- BURST_BEATS, 17, data beats per DMA burst (DMA awlen 16 -> 17 beats)
- ADDR_W, 30, DDR address width (matches DDR_ADDR_W)
- DATA_W, 256, data bus width (matches MIG_BUS_W); strobe width DATA_W/8

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester burst request / data valid
- req_addr  in  N_REQ*ADDR_W  per-requester burst start address, slice i = requester i
- req_wdata  in  N_REQ*DATA_W  per-requester write data
- req_wstrb  in  N_REQ*DATA_W/8  per-requester byte strobes
- req_ready  out  N_REQ  per-requester beat accept
- grant  out  N_REQ  one-hot current owner (registered)
- dma_valid  out  1  to DMA databus valid
- dma_addr  out  ADDR_W  to DMA databus addr
- dma_wdata  out  DATA_W  to DMA databus wdata
- dma_wstrb  out  DATA_W/8  to DMA databus wstrb
- dma_ready  in  1  DMA beat-accept pulse
- busy  out  1  high while a burst is owned (GRANT state)
- proto_err  out  1  sticky: owner dropped req_valid mid-burst

Behaviour:
- Clock and reset: single clk; rst_n is asynchronous and active-low. Assertion at any time, including mid-burst, immediately forces:
  - state=IDLE, grant=0, busy=0, proto_err=0
  - rr pointer=0, beat counter=0
  - dma_valid=0, req_ready=0
  - dma_addr/wdata/wstrb=0
- State machine: IDLE -> GRANT -> RELEASE -> IDLE.
- IDLE:
  - grant=0, dma_valid=0, req_ready=0.
  - If any req_valid bit is high, select the first set bit searching from the rr pointer upward, wrapping modulo N_REQ.
  - Register the one-hot grant, set pointer=(winner+1) mod N_REQ, go to GRANT.
  - Grant latency: 1 cycle from req_valid to grant/busy.
- GRANT:
  - dma_valid/addr/wdata/wstrb are combinationally muxed from the granted slice.
  - req_ready[g]=dma_ready; all other req_ready=0.
  - Beat counter (width clog2(BURST_BEATS+1)) increments on each dma_ready.
  - When dma_ready is high with counter==BURST_BEATS-1: clear the counter and go to RELEASE.
- RELEASE:
  - Exactly one cycle: grant=0, busy=0, dma_valid=0, req_ready=0.
  - Go to IDLE.
  - The bubble guarantees the DMA leaves its address and data phases before the next valid is seen.
  - Minimum burst-to-burst spacing: 2 idle cycles (RELEASE + IDLE arbitration).
- Grant persistence:
  - A grant is never revoked before BURST_BEATS beats are accepted.
  - Non-granted req_valid changes have no effect during GRANT/RELEASE.
- proto_err:
  - Set (sticky until reset) if, in GRANT, req_valid[g]==0 while dma_ready==1. The beat is still counted and forwarded.
  - The DMA pulls data unconditionally once the address is accepted, so requesters must hold valid and present data for the whole burst.
- Simultaneous requests: exactly one winner per arbitration, by rr order. A requester just served has lowest priority next round.
- Single requester continuously valid: re-granted every burst, 2-cycle gap between bursts.
- dma_ready outside GRANT: ignored, counter unchanged.
- Arithmetic: the pointer wraps from N_REQ-1 to 0. The counter never exceeds BURST_BEATS-1.

Test Plan:
- Reset: rst_n low -> all outputs 0. Release rst_n with req_valid=0 -> stays IDLE, grant=0.
- Single burst: req_valid=4'b0100, addr slice 2=0x100, DMA model pulses dma_ready 17 times -> grant=4'b0100 one cycle later; dma_addr=0x100; req_ready[2] mirrors dma_ready; after 17th beat grant=0 for 2 cycles.
- Round-robin fairness: all four req_valid held high for 8 bursts -> grant order 0,1,2,3,0,1,2,3; each owns exactly 17 beats.
- Priority rotation: req_valid=4'b1001 after requester 0 served -> next grant=4'b1000, then 4'b0001.
- Protocol error: owner drops req_valid at beat 5 while dma_ready high -> proto_err=1 and stays 1; burst still completes at 17 beats; next arbitration proceeds.
- Reset mid-burst: assert rst_n at beat 9 -> outputs 0 asynchronously; after release, new request gets grant with counter restarted (17 fresh beats) and pointer=0 priority.

Source files
------------

// File: rtl/axi_dma_w_arb.sv
// axi_dma_w_arb: round-robin, burst-granular arbiter sharing one write-DMA
// databus among N_REQ requesters. A winner owns the bus for exactly
// BURST_BEATS accepted beats, then a one-cycle release bubble precedes the
// next arbitration.
module axi_dma_w_arb #(
   parameter int N_REQ       = 4,
   parameter int BURST_BEATS = 17,
   parameter int ADDR_W      = 30,
   parameter int DATA_W      = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   input  logic [N_REQ*DATA_W/8-1:0] req_wstrb,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          grant,
   output logic                      dma_valid,
   output logic [ADDR_W-1:0]         dma_addr,
   output logic [DATA_W-1:0]         dma_wdata,
   output logic [DATA_W/8-1:0]       dma_wstrb,
   input  logic                      dma_ready,
   output logic                      busy,
   output logic                      proto_err
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W  = $clog2(BURST_BEATS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               perr_q, perr_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   win_next;
   logic [N_REQ-1:0]   win_onehot;

   // Round-robin search: first set req_valid bit at or above ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!win_found && req_valid[IDX_W'((32'(ptr_q) + k) % N_REQ)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((32'(ptr_q) + k) % N_REQ);
         end
      end
      win_next   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
   end

   // Next-state logic: arbitration, beat counting and sticky protocol error.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            cnt_d   = '0;
            if (win_found) begin
               grant_d = win_onehot;
               owner_d = win_idx;
               ptr_d   = win_next;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (dma_ready) begin
               // The DMA pulls the beat regardless; a missing valid is only flagged.
               if (!req_valid[owner_q]) perr_d = 1'b1;
               if (cnt_q == CNT_W'(BURST_BEATS - 1)) begin
                  cnt_d   = '0;
                  grant_d = '0;
                  state_d = RELEASE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RELEASE: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and arbitration registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

   // Databus mux from the owner's slice; everything is zero outside GRANT.
   always_comb begin
      busy      = (state_q == GRANT);
      dma_valid = 1'b0;
      dma_addr  = '0;
      dma_wdata = '0;
      dma_wstrb = '0;
      req_ready = '0;
      if (state_q == GRANT) begin
         dma_valid = req_valid[owner_q];
         dma_addr  = req_addr[owner_q*ADDR_W +: ADDR_W];
         dma_wdata = req_wdata[owner_q*DATA_W +: DATA_W];
         dma_wstrb = req_wstrb[owner_q*STRB_W +: STRB_W];
         req_ready = grant_q & {N_REQ{dma_ready}};
      end
   end

   assign grant     = grant_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_axi_dma_w_arb.sv
// tb_axi_dma_w_arb: randomized bench for axi_dma_w_arb with a burst-level
// reference model (round-robin pointer arithmetic, beat counting, sticky error).
module tb_axi_dma_w_arb;

   localparam int N      = 4;
   localparam int BB     = 17;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 256;
   localparam int STRB_W = DATA_W / 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          req_valid = '0;
   logic [N*ADDR_W-1:0]   req_addr;
   logic [N*DATA_W-1:0]   req_wdata;
   logic [N*STRB_W-1:0]   req_wstrb;
   logic [N-1:0]          req_ready;
   logic [N-1:0]          grant;
   logic                  dma_valid;
   logic [ADDR_W-1:0]     dma_addr;
   logic [DATA_W-1:0]     dma_wdata;
   logic [STRB_W-1:0]     dma_wstrb;
   logic                  dma_ready = 1'b0;
   logic                  busy;
   logic                  proto_err;

   logic [ADDR_W-1:0]     addr_a [N];
   logic [DATA_W-1:0]     data_a [N];
   logic [STRB_W-1:0]     strb_a [N];

   int                    n_checks = 0;
   int                    n_errors = 0;
   int                    m_ptr    = 0;
   bit                    m_perr   = 1'b0;

   always #5 clk = ~clk;

   // Pack per-requester stimulus into the flat DUT buses.
   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*ADDR_W +: ADDR_W]  = addr_a[i];
         req_wdata[i*DATA_W +: DATA_W] = data_a[i];
         req_wstrb[i*STRB_W +: STRB_W] = strb_a[i];
      end
   end

   axi_dma_w_arb #(
      .N_REQ       (N),
      .BURST_BEATS (BB),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_ready (req_ready),
      .grant     (grant),
      .dma_valid (dma_valid),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_wstrb (dma_wstrb),
      .dma_ready (dma_ready),
      .busy      (busy),
      .proto_err (proto_err)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W / 32; i++) r = {r[DATA_W-33:0], 32'($urandom)};
      return r;
   endfunction

   // Reference arbitration: first requester at or after the pointer, wrapping.
   function automatic int pick(input logic [N-1:0] rv, input int p);
      for (int k = 0; k < N; k++)
         if (rv[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_dvalid"}, dma_valid, 0);
      chk({tag, "_rready"}, req_ready, 0);
      chk({tag, "_addr"}, dma_addr, 0);
      chk({tag, "_wdata"}, dma_wdata, 0);
      chk({tag, "_wstrb"}, dma_wstrb, 0);
      chk({tag, "_perr"}, proto_err, 0);
   endtask

   // One burst: wait for the grant, feed BB beats with random ready gaps,
   // then check the two-cycle gap. drop_at/abort_at select a beat index at
   // which valid is dropped or reset is asserted (-1 disables).
   task automatic run_burst(input int drop_at, input int abort_at);
      int w, beats, guard;
      w = pick(req_valid, m_ptr);
      addr_a[w] = ADDR_W'($urandom);
      guard = 0;
      do begin
         step();
         guard++;
      end while (grant === '0 && guard < 5);
      chk("grant_lat", guard, 1);
      chk("grant_win", grant, 1 << w);
      chk("grant_busy", busy, 1);
      m_ptr = (w + 1) % N;

      beats = 0;
      guard = 0;
      while (beats < BB && guard < 200) begin
         dma_ready = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++) begin
            data_a[i] = rnd_data();
            strb_a[i] = STRB_W'($urandom);
         end
         if (beats == drop_at) begin
            req_valid[w] = 1'b0;
            dma_ready    = 1'b1;
         end
         if (beats == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            m_ptr  = 0;
            m_perr = 1'b0;
            dma_ready = 1'b0;
            return;
         end
         #1;
         chk("b_grant", grant, 1 << w);
         chk("b_busy", busy, 1);
         chk("b_dvalid", dma_valid, req_valid[w]);
         chk("b_addr", dma_addr, addr_a[w]);
         chk("b_wdata", dma_wdata, data_a[w]);
         chk("b_wstrb", dma_wstrb, strb_a[w]);
         chk("b_rready", req_ready, dma_ready ? (1 << w) : 0);
         if (!req_valid[w] && dma_ready) m_perr = 1'b1;
         step();
         guard++;
         if (dma_ready) beats++;
         req_valid[w] = 1'b1;
         chk("b_perr", proto_err, m_perr);
      end
      if (beats < BB) chk("beat_timeout", beats, BB);
      // Release cycle: stray dma_ready must be ignored.
      dma_ready = $urandom % 2;
      #1;
      chk("rel_grant", grant, 0);
      chk("rel_busy", busy, 0);
      chk("rel_dvalid", dma_valid, 0);
      chk("rel_rready", req_ready, 0);
      step();
      dma_ready = $urandom % 2;
      #1;
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rready", req_ready, 0);
      dma_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         addr_a[i] = '0;
         data_a[i] = '0;
         strb_a[i] = '0;
      end
      rst_n = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();
      step();
      step();
      chk("post_rst_grant", grant, 0);
      chk("post_rst_busy", busy, 0);

      // Single burst from requester 2.
      req_valid = 4'b0100;
      run_burst(-1, -1);
      req_valid = '0;

      // All requesters continuously valid: strict rotation.
      req_valid = 4'b1111;
      for (int b = 0; b < 8; b++) run_burst(-1, -1);

      // Serve requester 0, then 1001 must go to 3 and then back to 0.
      req_valid = 4'b0001;
      run_burst(-1, -1);
      req_valid = 4'b1001;
      run_burst(-1, -1);
      chk("rot_ptr_after3", m_ptr, 0);
      run_burst(-1, -1);

      // Owner drops valid at beat 5; error sticks, later bursts proceed.
      req_valid = 4'b0010;
      run_burst(5, -1);
      req_valid = 4'b0100;
      run_burst(-1, -1);

      // Random request patterns.
      for (int b = 0; b < 6; b++) begin
         req_valid = N'($urandom_range(1, (1 << N) - 1));
         run_burst(-1, -1);
      end

      // Reset at beat 9, then a fresh burst with pointer back at 0.
      req_valid = 4'b1111;
      run_burst(-1, 9);
      req_valid = '0;
      step();
      chk_all_zero("rst_hold");
      rst_n = 1'b1;
      step();
      chk("rst_rel_grant", grant, 0);
      req_valid = 4'b0110;
      run_burst(-1, -1);
      req_valid = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
